// File: rtl/fighter_action_fsm.sv
// Per-fighter action state machine advanced once per video frame.
// Produces the action state for the animation stage plus facing, attack and takeoff signals.
module fighter_action_fsm #(
    parameter int JUMPSQUAT_FRAMES = 3,
    parameter int ATTACK_FRAMES    = 12,
    parameter int LANDING_FRAMES   = 4,
    parameter int HITSTUN_FRAMES   = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_attack,
    input  logic       on_ground,
    input  logic       hit_taken,
    output logic [2:0] anim_state,
    output logic       facing_left,
    output logic       state_changed,
    output logic       attack_active,
    output logic       jump_pulse
);

    localparam int MAX_A    = (JUMPSQUAT_FRAMES > ATTACK_FRAMES) ? JUMPSQUAT_FRAMES : ATTACK_FRAMES;
    localparam int MAX_B    = (LANDING_FRAMES > HITSTUN_FRAMES) ? LANDING_FRAMES : HITSTUN_FRAMES;
    localparam int MAX_N    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TIMER_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [TIMER_W-1:0] JSQ_LOAD  = TIMER_W'(JUMPSQUAT_FRAMES - 1);
    localparam logic [TIMER_W-1:0] ATK_LOAD  = TIMER_W'(ATTACK_FRAMES - 1);
    localparam logic [TIMER_W-1:0] LAND_LOAD = TIMER_W'(LANDING_FRAMES - 1);
    localparam logic [TIMER_W-1:0] HIT_LOAD  = TIMER_W'(HITSTUN_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_JUMPSQUAT = 3'd2,
        ST_AIR       = 3'd3,
        ST_ATTACK    = 3'd4,
        ST_LANDING   = 3'd5,
        ST_HITSTUN   = 3'd6,
        ST_UNUSED    = 3'd7
    } state_e;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 facing_q, facing_d;
    logic                 changed_q, changed_d;
    logic                 jump_q, jump_d;

    logic                 one_dir;
    logic                 timer_zero;
    logic [TIMER_W-1:0]   timer_dec;

    assign one_dir    = btn_left ^ btn_right;
    assign timer_zero = (timer_q == '0);
    assign timer_dec  = timer_q - TIMER_W'(1);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves one unassigned (no latches).
        state_d   = state_q;
        timer_d   = timer_q;
        facing_d  = facing_q;
        changed_d = 1'b0;
        jump_d    = 1'b0;

        if (frame_tick) begin
            if ((state_q == ST_IDLE || state_q == ST_RUN) && one_dir) begin
                facing_d = btn_left;
            end

            if (hit_taken) begin
                state_d = ST_HITSTUN;
                timer_d = HIT_LOAD;
            end else begin
                unique case (state_q)
                    ST_IDLE, ST_RUN: begin
                        if (!on_ground) begin
                            state_d = ST_AIR;
                        end else if (btn_attack) begin
                            state_d = ST_ATTACK;
                            timer_d = ATK_LOAD;
                        end else if (btn_jump) begin
                            state_d = ST_JUMPSQUAT;
                            timer_d = JSQ_LOAD;
                        end else if (one_dir) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_JUMPSQUAT: begin
                        if (timer_zero) begin
                            state_d = ST_AIR;
                            jump_d  = 1'b1;
                        end else begin
                            timer_d = timer_dec;
                        end
                    end
                    ST_AIR: begin
                        if (on_ground) begin
                            state_d = ST_LANDING;
                            timer_d = LAND_LOAD;
                        end
                    end
                    // Attack and hitstun recover to the ground or air depending on where the fighter is.
                    ST_ATTACK, ST_HITSTUN: begin
                        if (timer_zero) begin
                            state_d = on_ground ? ST_IDLE : ST_AIR;
                        end else begin
                            timer_d = timer_dec;
                        end
                    end
                    ST_LANDING: begin
                        if (timer_zero) begin
                            state_d = ST_IDLE;
                        end else begin
                            timer_d = timer_dec;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            // A re-hit during hitstun restarts the animation even though the state is unchanged.
            changed_d = hit_taken || (state_d != state_q);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset clears only control state; there is no memory here that would need it skipped.
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            facing_q  <= 1'b0;
            changed_q <= 1'b0;
            jump_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            timer_q   <= timer_d;
            facing_q  <= facing_d;
            changed_q <= changed_d;
            jump_q    <= jump_d;
        end
    end

    assign anim_state    = state_q;
    assign facing_left   = facing_q;
    assign state_changed = changed_q;
    assign jump_pulse    = jump_q;
    assign attack_active = (state_q == ST_ATTACK);

endmodule

// File: tb/tb_fighter_action_fsm.sv
// Directed bench for fighter_action_fsm: each frame tick pushes its expected outputs
// to a scoreboard that is popped and compared once the registered outputs settle.
module tb_fighter_action_fsm;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_JSQ  = 3'd2;
    localparam logic [2:0] S_AIR  = 3'd3;
    localparam logic [2:0] S_ATK  = 3'd4;
    localparam logic [2:0] S_LAND = 3'd5;
    localparam logic [2:0] S_HIT  = 3'd6;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       btn_left, btn_right, btn_jump, btn_attack;
    logic       on_ground, hit_taken;
    logic [2:0] anim_state;
    logic       facing_left, state_changed, attack_active, jump_pulse;

    int    checks   = 0;
    int    failures = 0;
    string phase    = "init";

    typedef struct packed {
        logic [2:0] st;
        logic       f;
        logic       c;
        logic       j;
        logic       a;
    } exp_t;

    exp_t sb[$];

    fighter_action_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_jump     (btn_jump),
        .btn_attack   (btn_attack),
        .on_ground    (on_ground),
        .hit_taken    (hit_taken),
        .anim_state   (anim_state),
        .facing_left  (facing_left),
        .state_changed(state_changed),
        .attack_active(attack_active),
        .jump_pulse   (jump_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    // One frame tick with the given inputs, then one non-tick clock.
    task automatic step(input logic l, r, j, a, g, h,
                        input logic [2:0] es, input logic ef, ec, ej);
        exp_t e;
        @(negedge clk);
        btn_left   = l;
        btn_right  = r;
        btn_jump   = j;
        btn_attack = a;
        on_ground  = g;
        hit_taken  = h;
        frame_tick = 1'b1;
        e.st = es;
        e.f  = ef;
        e.c  = ec;
        e.j  = ej;
        e.a  = (es == S_ATK);
        sb.push_back(e);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s/scoreboard observed=empty expected=entry", phase);
        end else begin
            e = sb.pop_front();
            chk("anim_state",    anim_state,    e.st);
            chk("facing_left",   facing_left,   e.f);
            chk("state_changed", state_changed, e.c);
            chk("jump_pulse",    jump_pulse,    e.j);
            chk("attack_active", attack_active, e.a);
        end
        @(posedge clk);
        #1;
        chk("hold_state", anim_state,    es);
        chk("hold_chg",   state_changed, 1'b0);
        chk("hold_jump",  jump_pulse,    1'b0);
    endtask

    task automatic chk_reset_values();
        chk("rst_state",  anim_state,    S_IDLE);
        chk("rst_facing", facing_left,   1'b0);
        chk("rst_chg",    state_changed, 1'b0);
        chk("rst_attack", attack_active, 1'b0);
        chk("rst_jump",   jump_pulse,    1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b1;
        btn_left   = 1'b0;
        btn_right  = 1'b1;
        btn_jump   = 1'b0;
        btn_attack = 1'b0;
        on_ground  = 1'b1;
        hit_taken  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        phase = "reset";
        chk_reset_values();
        @(negedge clk);
        reset      = 1'b0;
        frame_tick = 1'b0;
        btn_right  = 1'b0;

        phase = "idle";
        repeat (10) step(0,0,0,0,1,0, S_IDLE,0,0,0);

        phase = "run";
        step(0,1,0,0,1,0, S_RUN, 0,1,0);
        step(0,0,0,0,1,0, S_IDLE,0,1,0);
        step(1,0,0,0,1,0, S_RUN, 1,1,0);
        step(1,0,0,0,1,0, S_RUN, 1,0,0);
        step(1,1,0,0,1,0, S_IDLE,1,1,0);
        step(0,1,0,0,1,0, S_RUN, 0,1,0);
        step(0,0,0,0,1,0, S_IDLE,0,1,0);

        phase = "jump";
        step(0,0,1,0,1,0, S_JSQ,0,1,0);
        step(0,0,1,1,1,0, S_JSQ,0,0,0);
        step(0,0,0,0,1,0, S_JSQ,0,0,0);
        step(0,0,0,0,1,0, S_AIR,0,1,1);
        repeat (5) step(1,0,1,1,0,0, S_AIR,0,0,0);
        step(0,0,0,0,1,0, S_LAND,0,1,0);
        repeat (3) step(0,1,0,0,1,0, S_LAND,0,0,0);
        step(0,0,0,0,1,0, S_IDLE,0,1,0);

        phase = "attack_ground";
        step(0,0,0,1,1,0, S_ATK,0,1,0);
        repeat (11) step(0,0,0,0,1,0, S_ATK,0,0,0);
        step(0,0,0,0,1,0, S_IDLE,0,1,0);

        phase = "attack_air";
        step(0,0,0,1,1,0, S_ATK,0,1,0);
        repeat (11) step(0,0,0,0,0,0, S_ATK,0,0,0);
        step(0,0,0,0,0,0, S_AIR,0,1,0);
        step(0,0,0,0,1,0, S_LAND,0,1,0);
        repeat (3) step(0,0,0,0,1,0, S_LAND,0,0,0);
        step(0,0,0,0,1,0, S_IDLE,0,1,0);

        phase = "hitstun";
        step(0,0,0,1,1,0, S_ATK,0,1,0);
        repeat (3) step(0,0,0,0,1,0, S_ATK,0,0,0);
        step(0,0,0,0,1,1, S_HIT,0,1,0);
        repeat (8) step(0,0,0,1,1,0, S_HIT,0,0,0);
        step(0,0,0,0,1,1, S_HIT,0,1,0);
        repeat (19) step(0,0,0,0,1,0, S_HIT,0,0,0);
        step(0,0,0,0,1,0, S_IDLE,0,1,0);

        phase = "freeze";
        step(1,0,0,0,1,0, S_RUN,1,1,0);
        step(1,0,0,1,1,0, S_ATK,1,1,0);
        repeat (3) step(0,0,0,0,1,0, S_ATK,1,0,0);
        @(negedge clk);
        hit_taken  = 1'b1;
        btn_jump   = 1'b1;
        btn_right  = 1'b1;
        on_ground  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            chk("frz_state",  anim_state,    S_ATK);
            chk("frz_chg",    state_changed, 1'b0);
            chk("frz_jump",   jump_pulse,    1'b0);
            chk("frz_facing", facing_left,   1'b1);
        end
        repeat (8) step(0,0,0,0,1,0, S_ATK,1,0,0);
        step(0,0,0,0,1,0, S_IDLE,1,1,0);

        phase = "reset_mid_hitstun";
        step(0,0,0,0,1,1, S_HIT,1,1,0);
        repeat (3) step(0,0,0,0,1,0, S_HIT,1,0,0);
        @(negedge clk);
        reset      = 1'b1;
        frame_tick = 1'b1;
        hit_taken  = 1'b1;
        btn_left   = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_values();
        @(negedge clk);
        reset      = 1'b0;
        frame_tick = 1'b0;
        hit_taken  = 1'b0;
        btn_left   = 1'b0;
        step(0,0,0,0,1,0, S_IDLE,0,0,0);
        step(0,0,0,1,1,0, S_ATK,0,1,0);
        repeat (11) step(0,0,0,0,1,0, S_ATK,0,0,0);
        step(0,0,0,0,1,0, S_IDLE,0,1,0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
